// File: rtl/roll_scan_ctrl_pkg.sv
// Shared definitions for the roll display blocks: controller states, the blank
// code understood by the segment decoder, and an index-width helper.
package roll_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } roll_state_e;

  // Width of an index into n items; never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/roll_scan_ctrl_if.sv
// Control/display bundle between the switch logic (master) and the roll
// scan controller (slave).
interface roll_scan_ctrl_if
  import roll_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEQ_LEN    = 8
) ();

  localparam int unsigned POS_W = idx_w(SEQ_LEN);

  logic                         en;
  logic                         pause;
  logic                         load;
  logic [DIGIT_W*SEQ_LEN-1:0]   load_data;
  logic [DIGIT_W-1:0]           dig_code;
  logic [NUM_DIGITS-1:0]        an;
  logic [POS_W-1:0]             roll_pos;
  logic                         wrap;

  modport master (
    output en, pause, load, load_data,
    input  dig_code, an, roll_pos, wrap
  );

  modport slave (
    input  en, pause, load, load_data,
    output dig_code, an, roll_pos, wrap
  );

endinterface

// File: rtl/roll_scan_ctrl_tick_gen.sv
// Free-running modulo-DIV counter that pulses tick on its terminal count while
// run is high; clr restarts the count and suppresses the pulse.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = run && !clr && (cnt_q == LAST);

endmodule

// File: rtl/roll_scan_ctrl.sv
// Roll display sequencer: multiplexes a scrolling window of a loaded BCD digit
// sequence onto one shared 7-segment decoder, one anode at a time.
module roll_scan_ctrl
  import roll_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEQ_LEN    = 8,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned ROLL_DIV   = 25000000
) (
  input logic             clk,
  input logic             rst_n,
  roll_scan_ctrl_if.slave bus
);

  localparam int unsigned POS_W  = idx_w(SEQ_LEN);
  localparam int unsigned SLOT_W = idx_w(NUM_DIGITS);
  localparam int unsigned SUM_W  = POS_W + 1;
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SEQ_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
  localparam logic [SUM_W-1:0]  SEQ_LEN_S = SUM_W'(SEQ_LEN);

  roll_state_e             state_q, state_d;
  logic [SLOT_W-1:0]       slot_q;
  logic [POS_W-1:0]        pos_q;
  logic                    wrap_q;
  logic [DIGIT_W-1:0]      seq_q [SEQ_LEN];
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [DIGIT_W-1:0]      dig_q, dig_d;
  logic [SUM_W-1:0]        win_sum;
  logic [POS_W-1:0]        win_idx;
  logic                    scan_tick;
  logic                    roll_tick;
  logic                    scanning;
  logic                    rolling;

  assign scanning = (state_q != IDLE);
  assign rolling  = (state_q == RUN);

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (scanning),
    .clr   (!scanning),
    .tick  (scan_tick)
  );

  // Load restarts the scroll step so the new number starts from a full step.
  tick_gen #(.DIV(ROLL_DIV)) u_roll_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (rolling),
    .clr   (bus.load),
    .tick  (roll_tick)
  );

  // Window index wraps by one compare-and-subtract since pos+slot < 2*SEQ_LEN.
  always_comb begin
    win_sum = SUM_W'(pos_q) + SUM_W'(slot_q);
    win_idx = (win_sum >= SEQ_LEN_S) ? POS_W'(win_sum - SEQ_LEN_S) : POS_W'(win_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    an_d    = '1;
    dig_d   = BLANK_CODE;
    unique case (state_q)
      IDLE:    if (bus.en) state_d = RUN;
      RUN:     if (!bus.en) state_d = IDLE; else if (bus.pause) state_d = PAUSE;
      PAUSE:   if (!bus.en) state_d = IDLE; else if (!bus.pause) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      an_d  = ~(NUM_DIGITS'(1) << slot_q);
      dig_d = seq_q[win_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (!scanning) begin
      slot_q <= '0;
    end else if (scan_tick) begin
      slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // A load overrides a coincident scroll step and never produces a wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.load) begin
        pos_q <= '0;
      end else if (roll_tick) begin
        if (pos_q == POS_LAST) begin
          pos_q  <= '0;
          wrap_q <= 1'b1;
        end else begin
          pos_q <= pos_q + POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SEQ_LEN; i++) seq_q[i] <= '0;
    end else if (bus.load) begin
      for (int unsigned i = 0; i < SEQ_LEN; i++) seq_q[i] <= bus.load_data[i*DIGIT_W +: DIGIT_W];
    end
  end

  // Code and enable share one register stage so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      dig_q <= BLANK_CODE;
    end else begin
      an_q  <= an_d;
      dig_q <= dig_d;
    end
  end

  assign bus.an       = an_q;
  assign bus.dig_code = dig_q;
  assign bus.roll_pos = pos_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_roll_scan_ctrl.sv
// Self-checking bench for roll_scan_ctrl: hand-derived vector table, corner
// sequences, and randomized traffic against an integer reference model.
module tb_roll_scan_ctrl;
  import roll_pkg::*;

  localparam int unsigned ND = 4;
  localparam int unsigned SL = 6;
  localparam int unsigned SD = 4;
  localparam int unsigned RD = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  roll_scan_ctrl_if #(.NUM_DIGITS(ND), .SEQ_LEN(SL)) bus ();

  roll_scan_ctrl #(
    .NUM_DIGITS(ND), .SEQ_LEN(SL), .SCAN_DIV(SD), .ROLL_DIV(RD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: 0=idle, 1=run, 2=pause
  int         m_mode, m_scan, m_slot, m_roll, m_pos;
  int         m_seq [SL];
  logic [3:0] e_an, e_dig;
  int         e_pos;
  logic       e_wrap;

  typedef struct {
    logic        en;
    logic        pause;
    logic        load;
    logic [23:0] data;
    int          cycles;
    logic [3:0]  an;
    logic [3:0]  dig;
    int          pos;
    logic        wrap;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_scan = 0; m_slot = 0; m_roll = 0; m_pos = 0;
    for (int i = 0; i < SL; i++) m_seq[i] = 0;
    e_an = 4'hF; e_dig = 4'hF; e_pos = 0; e_wrap = 1'b0;
  endtask

  // One rising edge of the specified behaviour, using the currently driven inputs.
  task automatic model_clock();
    if (m_mode == 0) begin
      e_an  = 4'hF;
      e_dig = 4'hF;
    end else begin
      e_an  = 4'hF ^ (4'(1) << m_slot);
      e_dig = 4'(m_seq[(m_pos + m_slot) % SL]);
    end
    e_wrap = 1'b0;
    if (bus.load) begin
      for (int i = 0; i < SL; i++) m_seq[i] = int'(bus.load_data[4*i +: 4]);
      m_pos  = 0;
      m_roll = 0;
    end else if (m_mode == 1) begin
      if (m_roll == RD - 1) begin
        m_roll = 0;
        m_pos  = (m_pos + 1) % SL;
        e_wrap = (m_pos == 0);
      end else begin
        m_roll++;
      end
    end
    if (m_mode == 0) begin
      m_scan = 0;
      m_slot = 0;
    end else if (m_scan == SD - 1) begin
      m_scan = 0;
      m_slot = (m_slot + 1) % ND;
    end else begin
      m_scan++;
    end
    if (!bus.en)          m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else                  m_mode = bus.pause ? 2 : 1;
    e_pos = m_pos;
  endtask

  task automatic drive(input logic en, input logic pause, input logic load, input logic [23:0] data);
    bus.en        = en;
    bus.pause     = pause;
    bus.load      = load;
    bus.load_data = data;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check("model_an",   32'(bus.an),       32'(e_an));
    check("model_dig",  32'(bus.dig_code), 32'(e_dig));
    check("model_pos",  32'(bus.roll_pos), 32'(e_pos));
    check("model_wrap", 32'(bus.wrap),     32'(e_wrap));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // en, pause, load, data, cycles, an, dig, pos, wrap
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 24'h987654,   1, 4'hF, 4'hF, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 24'h987654,   1, 4'hE, 4'h4, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 24'h987654,   3, 4'hE, 4'h4, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 24'h987654,   1, 4'hD, 4'h5, 0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 24'h987654,   4, 4'hB, 4'h6, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'h987654,   4, 4'h7, 4'h7, 0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 24'h987654,   4, 4'hE, 4'h4, 0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 24'h987654,  46, 4'h7, 4'h7, 0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 24'h987654,   1, 4'h7, 4'h7, 1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 24'h987654,   1, 4'hE, 4'h5, 1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 24'h987654, 204, 4'h7, 4'h5, 4, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 24'h987654, 115, 4'h7, 4'h6, 0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 24'h987654,   1, 4'hE, 4'h4, 0, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 24'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_an",   32'(bus.an),       32'hF);
    check("reset_dig",  32'(bus.dig_code), 32'hF);
    check("reset_pos",  32'(bus.roll_pos), 32'h0);
    check("reset_wrap", 32'(bus.wrap),     32'h0);
    rst_n = 1'b1;

    // Scan order, first scroll step, window wrap-around and the wrap pulse
    for (int r = 0; r < 13; r++) begin
      drive(tbl[r].en, tbl[r].pause, tbl[r].load, tbl[r].data);
      run(tbl[r].cycles);
      check($sformatf("row%0d_an", r),   32'(bus.an),       32'(tbl[r].an));
      check($sformatf("row%0d_dig", r),  32'(bus.dig_code), 32'(tbl[r].dig));
      check($sformatf("row%0d_pos", r),  32'(bus.roll_pos), 32'(tbl[r].pos));
      check($sformatf("row%0d_wrap", r), 32'(bus.wrap),     32'(tbl[r].wrap));
    end

    // Pause freezes the scroll count at 2; only the remaining 62 edges are needed
    drive(1'b1, 1'b1, 1'b0, 24'h987654);
    run(200);
    check("pause_pos", 32'(bus.roll_pos), 32'h0);
    check("pause_scanning", 32'(bus.an == 4'hF), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 24'h987654);
    run(62);
    check("resume_pos_before", 32'(bus.roll_pos), 32'h0);
    run(1);
    check("resume_pos_after", 32'(bus.roll_pos), 32'h1);

    // Load on the terminal count of the wrapping step
    run(319);
    check("pre_load_pos", 32'(bus.roll_pos), 32'h5);
    drive(1'b1, 1'b0, 1'b1, 24'h543210);
    run(1);
    check("load_tc_pos",  32'(bus.roll_pos), 32'h0);
    check("load_tc_wrap", 32'(bus.wrap),     32'h0);
    drive(1'b1, 1'b0, 1'b0, 24'h543210);
    run(1);
    check("load_new_an",  32'(bus.an),       32'hB);
    check("load_new_dig", 32'(bus.dig_code), 32'h2);

    // Disable mid-slot, then re-enable from slot 0
    drive(1'b0, 1'b0, 1'b0, 24'h543210);
    run(2);
    check("dis_an",  32'(bus.an),       32'hF);
    check("dis_dig", 32'(bus.dig_code), 32'hF);
    drive(1'b1, 1'b0, 1'b0, 24'h543210);
    run(2);
    check("reen_an",  32'(bus.an),       32'hE);
    check("reen_dig", 32'(bus.dig_code), 32'h0);
    check("reen_pos", 32'(bus.roll_pos), 32'h0);

    // Randomized traffic, including non-BCD digits in load_data
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 299) == 0), 24'($urandom));
      step();
    end

    // Asynchronous reset while running
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    run(70);
    #2 rst_n = 1'b0;
    #1;
    check("areset_an",   32'(bus.an),       32'hF);
    check("areset_dig",  32'(bus.dig_code), 32'hF);
    check("areset_pos",  32'(bus.roll_pos), 32'h0);
    check("areset_wrap", 32'(bus.wrap),     32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
